// File: rtl/key_gen_pkg.sv
// Shared constants for the key press emulator and related stimulus generators.
// State encoding is fixed so loopback monitors can decode it directly.
package key_gen_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESS_B = 3'd1,
    HOLD    = 3'd2,
    REL_B   = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          US_PER_MS = 1000;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift), one step per clock, reseeded on reset.
// No handshake: q is valid every cycle, new value one cycle after each edge.
module lfsr16
  import key_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  assign q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
  assign q   = q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/key_press_gen.sv
// Push-button emulator: one start yields bouncy press, stable hold, bouncy release on key_out.
// key_out falls the cycle after an accepted start; starts are ignored while busy or in DONE.
module key_press_gen
  import key_gen_pkg::*;
#(
  parameter int          CLK_FRE   = 50,
  parameter int          BOUNCE_US = 5000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        bounce_en,
  input  logic [15:0] hold_ms,
  output logic        key_out,
  output logic        busy,
  output logic        done
);

  localparam int PW = (CLK_FRE > 1) ? $clog2(CLK_FRE) : 1;
  localparam int BW = $clog2(BOUNCE_US + 1);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_FRE - 1);
  localparam logic [BW-1:0] BOUNCE_LAST = BW'(BOUNCE_US - 1);
  localparam logic [9:0]    US_LAST     = 10'(US_PER_MS - 1);

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [BW-1:0] bounce_q;
  logic [4:0]    glitch_q;
  logic [9:0]    us_q;
  logic [15:0]   ms_q;
  logic [15:0]   hold_q;
  logic          ben_q;
  logic          key_q;
  logic          busy_q;
  logic          done_q;

  logic [15:0]   lfsr;
  logic          unused_lfsr;
  logic          tick;
  logic          win_end;
  logic [4:0]    glitch_seed;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .q    (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:4];
  assign tick        = (presc_q == PRESC_LAST);
  assign glitch_seed = {1'b0, lfsr[3:0]} + 5'd1;
  // Without bounce the release window collapses to its single entry cycle.
  assign win_end     = !ben_q || (tick && (bounce_q == BOUNCE_LAST));

  assign key_out = key_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      bounce_q <= '0;
      glitch_q <= '0;
      us_q     <= '0;
      ms_q     <= '0;
      hold_q   <= '0;
      ben_q    <= 1'b0;
      key_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      presc_q <= tick ? '0 : presc_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            hold_q   <= (hold_ms == 16'd0) ? 16'd1 : hold_ms;
            ben_q    <= bounce_en;
            key_q    <= 1'b0;
            busy_q   <= 1'b1;
            presc_q  <= '0;
            bounce_q <= '0;
            glitch_q <= glitch_seed;
            us_q     <= '0;
            ms_q     <= '0;
            state_q  <= bounce_en ? PRESS_B : HOLD;
          end
        end
        PRESS_B, REL_B: begin
          // Window end takes priority over a glitch expiring on the same tick.
          if (win_end) begin
            presc_q  <= '0;
            bounce_q <= '0;
            if (state_q == PRESS_B) begin
              key_q   <= 1'b0;
              us_q    <= '0;
              ms_q    <= '0;
              state_q <= HOLD;
            end else begin
              key_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end
          end else if (tick) begin
            bounce_q <= bounce_q + 1'b1;
            if (glitch_q == 5'd1) begin
              key_q    <= ~key_q;
              glitch_q <= glitch_seed;
            end else begin
              glitch_q <= glitch_q - 5'd1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (us_q == US_LAST) begin
              us_q <= '0;
              if (ms_q == hold_q - 16'd1) begin
                key_q    <= 1'b1;
                presc_q  <= '0;
                bounce_q <= '0;
                glitch_q <= glitch_seed;
                state_q  <= REL_B;
              end else begin
                ms_q <= ms_q + 16'd1;
              end
            end else begin
              us_q <= us_q + 10'd1;
            end
          end
        end
        DONE: begin
          key_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_gen.sv
// Bench for key_press_gen at CLK_FRE=1, BOUNCE_US=20: vector table, corner sequences, random runs.
module tb_key_press_gen;

  localparam int W    = 20;
  localparam int MAXT = 3100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        bounce_en = 1'b0;
  logic [15:0] hold_ms = 16'd0;
  logic        key_out, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic        rk[MAXT], rb[MAXT], rd[MAXT];
  logic        ek[MAXT], eb[MAXT], ed[MAXT];
  logic        sk[MAXT];
  logic [15:0] lf[MAXT+1];
  int          xs[$];

  typedef struct {
    int   s;
    int   hold;
    logic ben;
    int   fall;
    int   rise;
    int   dn;
  } vec_t;
  vec_t tbl[5];

  key_press_gen #(.CLK_FRE(1), .BOUNCE_US(W), .LFSR_SEED(16'hACE1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bounce_en(bounce_en),
    .hold_ms  (hold_ms),
    .key_out  (key_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Toggle list for one bounce window: the glitch timer is loaded one cycle
  // before the window, each expiry flips the level and reloads from the LFSR.
  task automatic wiggle(input int ws, input int we, input logic lvl);
    logic lv;
    int   l, c;
    lv = lvl;
    l  = ws - 1;
    while (1) begin
      c = l + int'(lf[l][3:0]) + 1;
      if (c >= we) break;
      lv = ~lv;
      for (int t = c + 1; t <= we; t++) ek[t] = lv;
      l = c;
    end
  endtask

  task automatic build_model(input int s, input int hold, input logic ben, output int d);
    int h, h0, r0;
    h  = (hold == 0) ? 1 : hold;
    h0 = s + 1 + (ben ? W : 0);
    r0 = h0 + h * 1000;
    d  = r0 + (ben ? W : 1);
    for (int t = 0; t < MAXT; t++) begin
      ek[t] = !(t > s && t < r0);
      eb[t] = (t > s && t < d);
      ed[t] = (t == d);
    end
    if (ben) begin
      wiggle(s + 1, s + W, 1'b0);
      wiggle(r0, r0 + W - 1, 1'b1);
    end
  endtask

  task automatic run(input int s, input int hold, input logic ben, input int nlim);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t <= nlim; t++) begin
      rk[t] = key_out;
      rb[t] = busy;
      rd[t] = done;
      if (t == s) begin
        start     = 1'b1;
        hold_ms   = 16'(hold);
        bounce_en = ben;
      end else begin
        start = 1'b0;
        foreach (xs[i]) if (xs[i] == t) start = 1'b1;
        hold_ms   = 16'($urandom);
        bounce_en = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic cmp_wave(input string name, input int lo, input int hi);
    int bad, first;
    bad = 0;
    first = -1;
    for (int t = lo; t <= hi; t++) begin
      if (rk[t] !== ek[t] || rb[t] !== eb[t] || rd[t] !== ed[t]) begin
        bad++;
        if (first < 0) first = t;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d cycles differ from model, first at cycle %0d (key %b want %b, busy %b want %b, done %b want %b)",
               name, bad, first, rk[first], ek[first], rb[first], eb[first], rd[first], ed[first]);
    end
  endtask

  task automatic measure(input int hi, output int fall, output int rise, output int dcyc, output int dcnt);
    int best, zs;
    fall = -1; rise = -1; dcyc = -1; dcnt = 0; best = 0; zs = -1;
    for (int t = 0; t <= hi; t++) begin
      if (rk[t] == 1'b0) begin
        if (fall < 0) fall = t;
        if (zs < 0) zs = t;
        if (t - zs + 1 > best) begin
          best = t - zs + 1;
          rise = t + 1;
        end
      end else begin
        zs = -1;
      end
      if (rd[t] == 1'b1) begin
        dcnt++;
        if (dcyc < 0) dcyc = t;
      end
    end
  endtask

  initial begin
    int d, fall, rise, dc, dn, n, s, h;
    logic b;

    lf[0] = 16'hACE1;
    for (int i = 0; i < MAXT; i++)
      lf[i+1] = {1'b0, lf[i][15:1]} ^ (lf[i][0] ? 16'hB400 : 16'h0000);

    tbl[0] = '{10, 2, 1'b0, 11, 2011, 2012};
    tbl[1] = '{10, 1, 1'b1, 11, 1031, 1051};
    tbl[2] = '{5,  0, 1'b0, 6,  1006, 1007};
    tbl[3] = '{4,  3, 1'b1, 5,  3025, 3045};
    tbl[4] = '{20, 1, 1'b0, 21, 1021, 1022};

    foreach (tbl[i]) begin
      xs.delete();
      build_model(tbl[i].s, tbl[i].hold, tbl[i].ben, d);
      run(tbl[i].s, tbl[i].hold, tbl[i].ben, d + 3);
      if (i == 0) begin
        chk("reset key_out", int'(rk[0]), 1);
        chk("reset busy", int'(rb[0]), 0);
        chk("reset done", int'(rd[0]), 0);
      end
      measure(d + 3, fall, rise, dc, dn);
      chk($sformatf("vec%0d fall", i), fall, tbl[i].fall);
      chk($sformatf("vec%0d rise", i), rise, tbl[i].rise);
      chk($sformatf("vec%0d done cycle", i), dc, tbl[i].dn);
      chk($sformatf("vec%0d done count", i), dn, 1);
      cmp_wave($sformatf("vec%0d wave", i), 0, d + 3);
    end

    // Bouncy press with hold 1 ms: reference waveform kept for later comparison.
    xs.delete();
    build_model(10, 1, 1'b1, d);
    run(10, 1, 1'b1, 1060);
    n = 0;
    for (int t = 11; t <= 30; t++) if (rk[t] != rk[t-1]) n++;
    chk("press bounce has toggles", int'(n > 0), 1);
    n = 0;
    for (int t = 31; t <= 1030; t++) if (rk[t] != 1'b0) n++;
    chk("hold stable low cycles not low", n, 0);
    cmp_wave("bouncy hold1 wave", 0, 1060);
    for (int t = 0; t < MAXT; t++) sk[t] = (t <= 1060) ? rk[t] : 1'b1;

    // hold_ms=0 must reproduce the hold_ms=1 waveform exactly.
    run(10, 0, 1'b1, 1060);
    n = 0;
    for (int t = 0; t <= 1060; t++) if (rk[t] !== sk[t]) n++;
    chk("hold0 vs hold1 differing cycles", n, 0);
    cmp_wave("hold0 wave", 0, 1060);

    // Asynchronous reset in the middle of HOLD, then a reseeded rerun.
    run(10, 1, 1'b1, 500);
    chk("mid-hold key_out before reset", int'(key_out), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset key_out", int'(key_out), 1);
    chk("async reset busy", int'(busy), 0);
    run(10, 1, 1'b1, 1060);
    n = 0;
    for (int t = 0; t <= 1060; t++) if (rk[t] !== sk[t]) n++;
    chk("rerun after reset differing cycles", n, 0);

    // Held start, start during busy and in the DONE cycle are ignored; the
    // start still high in the first IDLE cycle is accepted.
    xs = '{11, 12, 13, 400, 1051, 1052};
    build_model(10, 1, 1'b1, d);
    run(10, 1, 1'b1, 1056);
    cmp_wave("ignored starts wave", 0, 1052);
    measure(1056, fall, rise, dc, dn);
    chk("ignored starts done count", dn, 1);
    chk("restart key_out low", int'(rk[1053]), 0);
    chk("restart busy high", int'(rb[1053]), 1);
    xs.delete();

    for (int k = 0; k < 4; k++) begin
      s = $urandom_range(2, 40);
      h = $urandom_range(0, 2);
      b = 1'($urandom_range(0, 1));
      build_model(s, h, b, d);
      run(s, h, b, d + 3);
      cmp_wave($sformatf("random%0d wave (s=%0d hold=%0d ben=%0d)", k, s, h, b), 0, d + 3);
      measure(d + 3, fall, rise, dc, dn);
      chk($sformatf("random%0d done cycle", k), dc, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
